// File: rtl/csr_pkg.sv
// ----------------------------------------------------------------------------
// csr_pkg
// Shared types for the trap sequencer and CSR-side logic.
//   trap_state_t        : sequencer state (IDLE, DRAIN, TAKE, REDIR)
//   trap_kind_t         : kind of event being sequenced
//   MTVEC_MODE_VECTORED : mtvec[1:0] encoding that selects vectored interrupts
// ----------------------------------------------------------------------------
package csr_pkg;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_DRAIN,
        TS_TAKE,
        TS_REDIR
    } trap_state_t;

    typedef enum logic [1:0] {
        TK_EXC,
        TK_INTR,
        TK_MRET
    } trap_kind_t;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_vec_calc.sv
// ----------------------------------------------------------------------------
// trap_vec_calc
// Combinational fetch-redirect target for a trap or MRET.
//   kind   in  trap_kind_t   exception / interrupt / MRET
//   cause  in  CAUSE_W       latched cause code
//   mtvec  in  XLEN          current mtvec (base + mode)
//   mepc   in  XLEN          current mepc
//   vec_pc out XLEN          target PC
// ----------------------------------------------------------------------------
module trap_vec_calc
    import csr_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int CAUSE_W = 4
) (
    input  trap_kind_t          kind,
    input  logic [CAUSE_W-1:0]  cause,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [XLEN-1:0]     mepc,
    output logic [XLEN-1:0]     vec_pc
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] cause_ext;

    assign base      = {mtvec[XLEN-1:2], 2'b00};
    assign cause_ext = {{(XLEN-CAUSE_W){1'b0}}, cause};

    // Only interrupts honour vectored mode; exceptions always land on the base.
    // The vectored sum wraps naturally at XLEN bits.
    always_comb begin
        vec_pc = base;
        case (kind)
            TK_INTR: begin
                if (mtvec[1:0] == MTVEC_MODE_VECTORED) begin
                    vec_pc = base + (cause_ext << 2);
                end
            end
            TK_MRET: vec_pc = mepc;
            default: vec_pc = base;
        endcase
    end

endmodule

// File: rtl/trap_ctrl.sv
// ----------------------------------------------------------------------------
// trap_ctrl
// Turns commit-stage trap events (exception / interrupt / MRET) into an
// ordered sequence: drain memory traffic, strobe the CSR file once, then
// redirect fetch and flush the pipeline.
//
// Ports
//   clk, reset (synchronous, active-high)
//   cmt_valid/cmt_pc/cmt_exc/cmt_cause/cmt_mret : committing instruction
//   intr_pending/intr_cause                      : pending interrupt
//   mem_busy                                     : data-bus transaction outstanding
//   mtvec/mepc                                   : current CSR values
//   stall_o/flush_o                              : pipeline control
//   redirect_valid/redirect_pc                   : fetch redirect
//   csr_trap/csr_trap_intr/csr_trap_cause/csr_trap_epc : trap-entry strobe
//   csr_mret                                     : MRET strobe
//   busy                                         : sequence in progress
//
// Optional feature: define TRAP_CTRL_STATS_EN to add trap_cnt / intr_cnt.
// ----------------------------------------------------------------------------
module trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int CAUSE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmt_valid,
    input  logic [XLEN-1:0]     cmt_pc,
    input  logic                cmt_exc,
    input  logic [CAUSE_W-1:0]  cmt_cause,
    input  logic                cmt_mret,
    input  logic                intr_pending,
    input  logic [CAUSE_W-1:0]  intr_cause,
    input  logic                mem_busy,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [XLEN-1:0]     mepc,
    output logic                stall_o,
    output logic                flush_o,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                csr_trap,
    output logic                csr_trap_intr,
    output logic [CAUSE_W-1:0]  csr_trap_cause,
    output logic [XLEN-1:0]     csr_trap_epc,
    output logic                csr_mret,
`ifdef TRAP_CTRL_STATS_EN
    output logic [CNT_W-1:0]    trap_cnt,
    output logic [CNT_W-1:0]    intr_cnt,
`endif
    output logic                busy
);

    trap_state_t        state;
    trap_kind_t         kind;
    logic [CAUSE_W-1:0] cause_q;
    logic [XLEN-1:0]    epc_q;
    logic [XLEN-1:0]    vec_pc;
    logic               accept;
    logic               in_take;
    logic               in_redir;

    // An event is any of the three sources while an instruction commits;
    // a pending interrupt without a commit waits for the next one.
    assign accept   = (state == TS_IDLE) && cmt_valid &&
                      (cmt_exc || intr_pending || cmt_mret);
    assign in_take  = (state == TS_TAKE);
    assign in_redir = (state == TS_REDIR);

    // Sequencer. Priority exc > intr > mret; the commit inputs are only
    // looked at in IDLE, so a losing interrupt simply stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TS_IDLE;
            kind    <= TK_EXC;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            case (state)
                TS_IDLE: begin
                    if (accept) begin
                        epc_q <= cmt_pc;
                        state <= mem_busy ? TS_DRAIN : TS_TAKE;
                        if (cmt_exc) begin
                            kind    <= TK_EXC;
                            cause_q <= cmt_cause;
                        end else if (intr_pending) begin
                            kind    <= TK_INTR;
                            cause_q <= intr_cause;
                        end else begin
                            kind    <= TK_MRET;
                            cause_q <= '0;
                        end
                    end
                end
                TS_DRAIN: begin
                    if (!mem_busy) begin
                        state <= TS_TAKE;
                    end
                end
                TS_TAKE:  state <= TS_REDIR;
                TS_REDIR: state <= TS_IDLE;
                default:  state <= TS_IDLE;
            endcase
        end
    end

    trap_vec_calc #(
        .XLEN    (XLEN),
        .CAUSE_W (CAUSE_W)
    ) u_vec_calc (
        .kind   (kind),
        .cause  (cause_q),
        .mtvec  (mtvec),
        .mepc   (mepc),
        .vec_pc (vec_pc)
    );

    // Everything except stall_o decodes flopped state only, so nothing from
    // the commit stage can glitch the CSR strobes. stall_o must also cover
    // the accept cycle so the trapping instruction does not retire.
    assign busy           = (state != TS_IDLE);
    assign stall_o        = busy || accept;
    assign csr_trap       = in_take && (kind != TK_MRET);
    assign csr_mret       = in_take && (kind == TK_MRET);
    assign csr_trap_intr  = csr_trap && (kind == TK_INTR);
    assign csr_trap_cause = csr_trap ? cause_q : '0;
    assign csr_trap_epc   = csr_trap ? epc_q : '0;
    assign flush_o        = in_redir;
    assign redirect_valid = in_redir;
    // mtvec/mepc are read here, one edge after the CSR file has been updated.
    assign redirect_pc    = in_redir ? vec_pc : '0;

`ifdef TRAP_CTRL_STATS_EN
    // Free-running statistics, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_cnt <= '0;
            intr_cnt <= '0;
        end else if (csr_trap) begin
            trap_cnt <= trap_cnt + 1'b1;
            if (csr_trap_intr) begin
                intr_cnt <= intr_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_trap_ctrl
// Directed, table-driven bench for trap_ctrl. Inputs change just after the
// falling edge and outputs are sampled 1ns later, well away from the rising
// edge. Define TRAP_CTRL_STATS_EN to also cover the statistics counters.
// ----------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam int XLEN    = 64;
    localparam int CAUSE_W = 4;
    localparam int CNT_W   = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmt_valid;
    logic [XLEN-1:0]    cmt_pc;
    logic               cmt_exc;
    logic [CAUSE_W-1:0] cmt_cause;
    logic               cmt_mret;
    logic               intr_pending;
    logic [CAUSE_W-1:0] intr_cause;
    logic               mem_busy;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc;
    logic               stall_o;
    logic               flush_o;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               csr_trap;
    logic               csr_trap_intr;
    logic [CAUSE_W-1:0] csr_trap_cause;
    logic [XLEN-1:0]    csr_trap_epc;
    logic               csr_mret;
    logic               busy;
`ifdef TRAP_CTRL_STATS_EN
    logic [CNT_W-1:0]   trap_cnt;
    logic [CNT_W-1:0]   intr_cnt;
`endif

    always #5 clk = ~clk;

    trap_ctrl #(
        .XLEN    (XLEN),
        .CAUSE_W (CAUSE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmt_valid      (cmt_valid),
        .cmt_pc         (cmt_pc),
        .cmt_exc        (cmt_exc),
        .cmt_cause      (cmt_cause),
        .cmt_mret       (cmt_mret),
        .intr_pending   (intr_pending),
        .intr_cause     (intr_cause),
        .mem_busy       (mem_busy),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .csr_trap       (csr_trap),
        .csr_trap_intr  (csr_trap_intr),
        .csr_trap_cause (csr_trap_cause),
        .csr_trap_epc   (csr_trap_epc),
        .csr_mret       (csr_mret),
`ifdef TRAP_CTRL_STATS_EN
        .trap_cnt       (trap_cnt),
        .intr_cnt       (intr_cnt),
`endif
        .busy           (busy)
    );

    typedef struct {
        logic [XLEN-1:0]    pc;
        logic               exc;
        logic               mret;
        logic               intr;
        logic [CAUSE_W-1:0] cause;
        logic [CAUSE_W-1:0] icause;
        logic [XLEN-1:0]    mtvec;
        logic [XLEN-1:0]    mepc;
        int                 drain;
        logic               e_trap;
        logic               e_mret;
        logic               e_intr;
        logic [CAUSE_W-1:0] e_cause;
        logic [XLEN-1:0]    e_rpc;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_trap = 0;
    int exp_intr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [XLEN-1:0] pc, input logic exc, input logic mret,
                                input logic intr, input logic [CAUSE_W-1:0] cause,
                                input logic [CAUSE_W-1:0] icause, input logic [XLEN-1:0] tv,
                                input logic [XLEN-1:0] ep, input int drain,
                                input logic e_trap, input logic e_mret, input logic e_intr,
                                input logic [CAUSE_W-1:0] e_cause, input logic [XLEN-1:0] e_rpc);
        vec_t v;
        v.pc = pc; v.exc = exc; v.mret = mret; v.intr = intr;
        v.cause = cause; v.icause = icause; v.mtvec = tv; v.mepc = ep;
        v.drain = drain; v.e_trap = e_trap; v.e_mret = e_mret; v.e_intr = e_intr;
        v.e_cause = e_cause; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic clear_commit();
        cmt_valid = 1'b0;
        cmt_exc   = 1'b0;
        cmt_mret  = 1'b0;
        cmt_cause = '0;
    endtask

    // Drive one event at the current falling edge and follow it through
    // DRAIN (v.drain cycles), TAKE, REDIR and back to IDLE.
    task automatic applyStimulus(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        cmt_valid    = 1'b1;
        cmt_pc       = v.pc;
        cmt_exc      = v.exc;
        cmt_mret     = v.mret;
        cmt_cause    = v.cause;
        intr_pending = v.intr;
        intr_cause   = v.icause;
        mtvec        = v.mtvec;
        mepc         = v.mepc;
        mem_busy     = (v.drain > 0);
        #1;
        check({p, "_accept_stall"}, stall_o, 1'b1);
        check({p, "_accept_busy"}, busy, 1'b0);
        check({p, "_accept_trap"}, csr_trap, 1'b0);
        @(negedge clk);
        clear_commit();
        for (int d = 0; d < v.drain; d++) begin
            mem_busy = (d < v.drain - 1);
            #1;
            check({p, $sformatf("_drain%0d_stall", d)}, stall_o, 1'b1);
            check({p, $sformatf("_drain%0d_trap", d)}, csr_trap, 1'b0);
            check({p, $sformatf("_drain%0d_mret", d)}, csr_mret, 1'b0);
            @(negedge clk);
        end
        mem_busy = 1'b0;
        #1;
        checkOutput(v, p);
        @(negedge clk);
        #1;
        check({p, "_redir_flush"}, flush_o, 1'b1);
        check({p, "_redir_valid"}, redirect_valid, 1'b1);
        check({p, "_redir_pc"}, redirect_pc, v.e_rpc);
        check({p, "_redir_stall"}, stall_o, 1'b1);
        check({p, "_redir_trap"}, csr_trap, 1'b0);
        @(negedge clk);
        intr_pending = 1'b0;
        #1;
        check({p, "_idle_busy"}, busy, 1'b0);
        check({p, "_idle_stall"}, stall_o, 1'b0);
        check({p, "_idle_flush"}, flush_o, 1'b0);
        @(negedge clk);
    endtask

    // TAKE-cycle outputs.
    task automatic checkOutput(input vec_t v, input string p);
        check({p, "_take_trap"}, csr_trap, v.e_trap);
        check({p, "_take_mret"}, csr_mret, v.e_mret);
        check({p, "_take_intr"}, csr_trap_intr, v.e_intr);
        check({p, "_take_cause"}, csr_trap_cause, v.e_trap ? v.e_cause : '0);
        check({p, "_take_epc"}, csr_trap_epc, v.e_trap ? v.pc : '0);
        check({p, "_take_stall"}, stall_o, 1'b1);
        check({p, "_take_redir"}, redirect_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = mk(64'h8000_0010, 1, 0, 0, 4'd8, 4'd0, 64'h8000_0100, 64'h0, 0, 1, 0, 0, 4'd8, 64'h8000_0100);
        vecs[1] = mk(64'h8000_0010, 1, 0, 0, 4'd8, 4'd0, 64'h8000_0100, 64'h0, 3, 1, 0, 0, 4'd8, 64'h8000_0100);
        vecs[2] = mk(64'h8000_0040, 0, 0, 1, 4'd0, 4'd7, 64'h8000_0101, 64'h0, 0, 1, 0, 1, 4'd7, 64'h8000_011C);
        vecs[3] = mk(64'h8000_0060, 1, 0, 1, 4'd2, 4'd11, 64'h8000_0101, 64'h0, 0, 1, 0, 0, 4'd2, 64'h8000_0100);
        vecs[4] = mk(64'h8000_0080, 0, 0, 1, 4'd0, 4'd11, 64'h8000_0101, 64'h0, 0, 1, 0, 1, 4'd11, 64'h8000_012C);
        vecs[5] = mk(64'h8000_0090, 0, 1, 0, 4'd0, 4'd0, 64'h8000_0101, 64'h8000_0200, 0, 0, 1, 0, 4'd0, 64'h8000_0200);
        vecs[6] = mk(64'h8000_00A0, 0, 1, 1, 4'd0, 4'd3, 64'h8000_0103, 64'h8000_0200, 0, 1, 0, 1, 4'd3, 64'h8000_0100);
        vecs[7] = mk(64'h8000_00B0, 0, 0, 1, 4'd0, 4'd15, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0, 1, 1, 0, 1, 4'd15, 64'h38);
        vecs[8] = mk(64'h8000_00C0, 0, 1, 0, 4'd0, 4'd0, 64'h8000_0100, 64'h1234, 2, 0, 1, 0, 4'd0, 64'h1234);
        vecs[9] = mk(64'h8000_00D0, 1, 0, 0, 4'd5, 4'd0, 64'h8000_0001, 64'h0, 0, 1, 0, 0, 4'd5, 64'h8000_0000);

        reset        = 1'b1;
        clear_commit();
        cmt_pc       = '0;
        intr_pending = 1'b0;
        intr_cause   = '0;
        mem_busy     = 1'b0;
        mtvec        = '0;
        mepc         = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_trap", csr_trap, 1'b0);
        check("rst_redir", redirect_valid, 1'b0);
        check("rst_epc", csr_trap_epc, '0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
            if (vecs[i].e_trap) exp_trap++;
            if (vecs[i].e_intr) exp_intr++;
        end
`ifdef TRAP_CTRL_STATS_EN
        check("cnt_trap", trap_cnt, exp_trap);
        check("cnt_intr", intr_cnt, exp_intr);
`endif

        // Pending interrupt without a commit is held, never accepted.
        intr_pending = 1'b1;
        intr_cause   = 4'd9;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d_busy", c), busy, 1'b0);
            check($sformatf("hold%0d_stall", c), stall_o, 1'b0);
            @(negedge clk);
        end
        intr_pending = 1'b0;

        // Reset while draining aborts the event for good.
        cmt_valid = 1'b1;
        cmt_exc   = 1'b1;
        cmt_cause = 4'd4;
        cmt_pc    = 64'h8000_0300;
        mem_busy  = 1'b1;
        @(negedge clk);
        clear_commit();
        #1;
        check("abort_drain_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_stall", stall_o, 1'b0);
        check("abort_flush", flush_o, 1'b0);
        reset    = 1'b0;
        mem_busy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("abort%0d_trap", c), csr_trap, 1'b0);
            check($sformatf("abort%0d_redir", c), redirect_valid, 1'b0);
        end
`ifdef TRAP_CTRL_STATS_EN
        check("abort_cnt_trap", trap_cnt, '0);
        check("abort_cnt_intr", intr_cnt, '0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
